// File: rtl/pipelined_mac_stream.sv
// Three-stage streaming datapath: out = (a+b)*d -/+ c at exact 2W+2-bit width.
// Valid/ready on both sides; a single global stall freezes every stage.
module pipelined_mac_stream #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [W-1:0]       c,
  input  logic [W-1:0]       d,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W+1:0]     out,
  output logic [CNT_W-1:0]   done_count
);

  localparam int PW = 2*W + 1;
  localparam int RW = 2*W + 2;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic         m;
  } s1_t;

  typedef struct packed {
    logic [PW-1:0] p;
    logic [W-1:0]  c;
    logic          m;
  } s2_t;

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic             v3_q, v3_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [RW-1:0]    r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          stall;
  logic          acc;
  logic          fire;
  logic [W:0]    sum;
  logic [PW-1:0] prod;
  logic [RW-1:0] pe;
  logic [RW-1:0] ce;

  assign stall = v3_q && !out_ready;
  assign acc   = in_valid && !stall;
  assign fire  = v3_q && out_ready;

  // (a+b) needs W+1 bits; times d fits exactly in 2W+1
  assign sum  = {1'b0, s1_q.a} + {1'b0, s1_q.b};
  assign prod = PW'(sum) * PW'(s1_q.d);
  assign pe   = RW'(s2_q.p);
  assign ce   = RW'(s2_q.c);

  always_comb begin
    v1_d  = v1_q;
    v2_d  = v2_q;
    v3_d  = v3_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    r_d   = r_q;
    cnt_d = cnt_q;
    if (!stall) begin
      v1_d = in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      if (acc) begin
        s1_d = {a, b, c, d, mode};
      end
      if (v1_q) begin
        s2_d = {prod, s1_q.c, s1_q.m};
      end
      // bubbles leave the output register untouched
      if (v2_q) begin
        r_d = s2_q.m ? (pe + ce) : (pe - ce);
      end
    end
    if (fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      r_q   <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready   = !stall;
  assign out_valid  = v3_q;
  assign out        = r_q;
  assign done_count = cnt_q;

endmodule

// File: tb/tb_pipelined_mac_stream.sv
// Bench for pipelined_mac_stream: directed corners, stalls, resets,
// counter wrap and random traffic against a queue-based reference.
module tb_pipelined_mac_stream;

  localparam int W  = 8;
  localparam int RW = 2*W + 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0, b = '0, c = '0, d = '0;
  logic          mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] out;
  logic [15:0]   done_count;

  logic          w_in_valid = 1'b0;
  logic          w_in_ready;
  logic          w_out_valid;
  logic [RW-1:0] w_out;
  logic [3:0]    w_done;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = '0;
  logic [RW-1:0] expq[$];

  always #5 clock = ~clock;

  pipelined_mac_stream #(.W(W), .CNT_W(16)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .done_count(done_count)
  );

  pipelined_mac_stream #(.W(W), .CNT_W(4)) u_wrap (
    .clock(clock), .reset_n(reset_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(a), .b(b), .c(c), .d(d), .mode(mode),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out(w_out), .done_count(w_done)
  );

  function automatic logic [RW-1:0] model(int unsigned ua, int unsigned ub,
                                          int unsigned uc, int unsigned ud,
                                          bit m);
    longint r;
    r = longint'(ua + ub) * longint'(ud);
    r = m ? r + longint'(uc) : r - longint'(uc);
    return RW'(r);
  endfunction

  // One clock: bookkeeping on pre-edge values, then advance to next negedge.
  task automatic cycle();
    logic [RW-1:0] held;
    logic [RW-1:0] e;
    bit st;
    #1;
    n_cmp++;
    if (in_ready !== !(out_valid && !out_ready)) begin
      n_err++;
      $display("FAIL in_ready: got %b want %b", in_ready,
               !(out_valid && !out_ready));
    end
    if (out_valid === 1'b1 && out_ready) begin
      n_cmp++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got %h want none", out);
      end else begin
        e = expq.pop_front();
        if (out !== e) begin
          n_err++;
          $display("FAIL result: got %h want %h", out, e);
        end
      end
      exp_cnt++;
    end
    if (in_valid && in_ready === 1'b1)
      expq.push_back(model(a, b, c, d, mode));
    st = (out_valid === 1'b1) && !out_ready;
    held = out;
    @(posedge clock);
    @(negedge clock);
    if (st) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out !== held) begin
        n_err++;
        $display("FAIL stall_hold: got v=%b %h want v=1 %h",
                 out_valid, out, held);
      end
    end
    n_cmp++;
    if (done_count !== exp_cnt) begin
      n_err++;
      $display("FAIL done_count: got %0d want %0d", done_count, exp_cnt);
    end
  endtask

  task automatic randomize_ops();
    a = W'($urandom);
    b = W'($urandom);
    c = W'($urandom);
    d = W'($urandom);
    mode = 1'($urandom);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && expq.size() != 0; i++) cycle();
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", expq.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    w_in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || out !== '0 || done_count !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b out=%h cnt=%0d want 0/0/0",
               out_valid, out, done_count);
    end
    reset_n = 1'b1;
    expq.delete();
    exp_cnt = '0;
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [7:0]    ta[5] = '{3, 3, 0, 255, 255};
    logic [7:0]    tb[5] = '{2, 2, 1, 255, 255};
    logic [7:0]    tc[5] = '{7, 7, 200, 255, 255};
    logic [7:0]    td[5] = '{5, 5, 1, 255, 255};
    bit            tm[5] = '{0, 1, 0, 1, 0};
    logic [RW-1:0] tx[5] = '{18'd18, 18'd32, 18'h3FF39, 18'd130305, 18'd129795};
    for (int i = 0; i < 5; i++) begin
      a = ta[i]; b = tb[i]; c = tc[i]; d = td[i]; mode = tm[i];
      in_valid = 1'b1;
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL latency_e0[%0d]: got %b want 0", i, out_valid);
      end
      cycle();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL latency_e1[%0d]: got %b want 0", i, out_valid);
      end
      cycle();
      n_cmp++;
      if (out_valid !== 1'b1 || out !== tx[i]) begin
        n_err++;
        $display("FAIL directed[%0d]: got v=%b %h want v=1 %h",
                 i, out_valid, out, tx[i]);
      end
      cycle();
      if (i == 0) begin
        n_cmp++;
        if (done_count !== 16'd1) begin
          n_err++;
          $display("FAIL first_count: got %0d want 1", done_count);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    bit took;
    test_reset();
    randomize_ops();
    for (int cyc = 1; cyc <= 100 && !(sent == 10 && expq.size() == 0); cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid = (sent < 10);
      #1;
      took = in_valid && in_ready;
      cycle();
      if (took) begin
        sent++;
        randomize_ops();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (sent != 10 || expq.size() != 0 || done_count !== 16'd10) begin
      n_err++;
      $display("FAIL back_to_back: got sent=%0d pend=%0d cnt=%0d want 10/0/10",
               sent, expq.size(), done_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      randomize_ops();
      cycle();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1;
    randomize_ops();
    cycle();
    randomize_ops();
    cycle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out !== '0 || done_count !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b out=%h cnt=%0d want 0/0/0",
               out_valid, out, done_count);
    end
    expq.delete();
    exp_cnt = '0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stale_result: got %b want 0", out_valid);
      end
    end
    a = 1; b = 1; c = 1; d = 1; mode = 1'b0;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    n_cmp++;
    if (out_valid !== 1'b1 || out !== 18'd1) begin
      n_err++;
      $display("FAIL post_reset: got v=%b %h want v=1 1", out_valid, out);
    end
    cycle();
  endtask

  task automatic test_wrap();
    test_reset();
    for (int i = 0; i < 17; i++) begin
      w_in_valid = 1'b1;
      randomize_ops();
      cycle();
    end
    w_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    n_cmp++;
    if (w_done !== 4'd1) begin
      n_err++;
      $display("FAIL count_wrap: got %0d want 1", w_done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
